// File: rtl/dm_master.sv
// Data-memory initiator: turns single read/write and multi-word fill/copy
// commands into a registered WR/ADDR/IN_DATA stream for a passive RAM.
module dm_master #(
    parameter int DATA_W = 11,
    parameter int ADDR_W = 11
) (
    input  logic              CLK_i,
    input  logic              RST_n_i,
    input  logic              CMD_VALID_i,
    output logic              CMD_READY_o,
    input  logic [1:0]        CMD_OP_i,
    input  logic [ADDR_W-1:0] CMD_ADDR_i,
    input  logic [ADDR_W-1:0] CMD_SRC_i,
    input  logic [ADDR_W-1:0] CMD_LEN_i,
    input  logic [DATA_W-1:0] CMD_DATA_i,
    output logic              RSP_VALID_o,
    output logic [DATA_W-1:0] RSP_DATA_o,
    output logic              BUSY_o,
    output logic              WR_o,
    output logic [ADDR_W-1:0] ADDR_dm_o,
    output logic [DATA_W-1:0] IN_DATA_o,
    input  logic [DATA_W-1:0] OUT_DATA_i
);

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_COPY  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_FILL,
        S_CP_RD,
        S_CP_WR,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   in_data_q, in_data_d;

    // RAM-side outputs are computed one cycle ahead and registered, so the
    // access for a state is already on the port while that state is active.
    always_comb begin
        // NOTE: every signal gets its default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        dst_d      = dst_q;
        src_d      = src_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        in_data_d  = in_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (CMD_VALID_i) begin
                    dst_d = CMD_ADDR_i;
                    src_d = CMD_SRC_i;
                    cnt_d = CMD_LEN_i;
                    unique case (op_t'(CMD_OP_i))
                        OP_READ: begin
                            state_d = S_RD;
                            addr_d  = CMD_ADDR_i;
                        end
                        OP_WRITE: begin
                            state_d   = S_WR;
                            addr_d    = CMD_ADDR_i;
                            wr_d      = 1'b1;
                            in_data_d = CMD_DATA_i;
                        end
                        OP_FILL: begin
                            if (CMD_LEN_i == ADDR_ZERO) begin
                                state_d = S_DONE;
                            end else begin
                                state_d   = S_FILL;
                                addr_d    = CMD_ADDR_i;
                                wr_d      = 1'b1;
                                in_data_d = CMD_DATA_i;
                            end
                        end
                        OP_COPY: begin
                            if (CMD_LEN_i == ADDR_ZERO) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_CP_RD;
                                addr_d  = CMD_SRC_i;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_RD: begin
                rsp_data_d = OUT_DATA_i;
                state_d    = S_DONE;
            end
            S_WR: begin
                rsp_data_d = in_data_q;
                state_d    = S_DONE;
            end
            S_FILL: begin
                cnt_d = cnt_q - ADDR_ONE;
                if (cnt_q == ADDR_ONE) begin
                    rsp_data_d = in_data_q;
                    state_d    = S_DONE;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                    wr_d   = 1'b1;
                end
            end
            S_CP_RD: begin
                state_d   = S_CP_WR;
                addr_d    = dst_q;
                wr_d      = 1'b1;
                in_data_d = OUT_DATA_i;
            end
            S_CP_WR: begin
                cnt_d = cnt_q - ADDR_ONE;
                src_d = src_q + ADDR_ONE;
                dst_d = dst_q + ADDR_ONE;
                if (cnt_q == ADDR_ONE) begin
                    rsp_data_d = in_data_q;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_CP_RD;
                    addr_d  = src_q + ADDR_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge CLK_i or negedge RST_n_i) begin
        if (!RST_n_i) begin
            state_q    <= S_IDLE;
            dst_q      <= '0;
            src_q      <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            in_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            dst_q      <= dst_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            in_data_q  <= in_data_d;
        end
    end

    assign CMD_READY_o = (state_q == S_IDLE);
    assign BUSY_o      = (state_q != S_IDLE);
    assign RSP_VALID_o = (state_q == S_DONE);
    assign RSP_DATA_o  = rsp_data_q;
    assign WR_o        = wr_q;
    assign ADDR_dm_o   = addr_q;
    assign IN_DATA_o   = in_data_q;

endmodule

// File: tb/tb_dm_master.sv
// Directed bench for dm_master with a behavioural RAM on the data-memory port.
module tb_dm_master;

    logic        CLK_i = 1'b0;
    logic        RST_n_i = 1'b0;
    logic        CMD_VALID_i = 1'b0;
    logic        CMD_READY_o;
    logic [1:0]  CMD_OP_i = 2'b00;
    logic [10:0] CMD_ADDR_i = '0;
    logic [10:0] CMD_SRC_i = '0;
    logic [10:0] CMD_LEN_i = '0;
    logic [10:0] CMD_DATA_i = '0;
    logic        RSP_VALID_o;
    logic [10:0] RSP_DATA_o;
    logic        BUSY_o;
    logic        WR_o;
    logic [10:0] ADDR_dm_o;
    logic [10:0] IN_DATA_o;
    logic [10:0] OUT_DATA_i;

    logic [10:0] mem [0:2047];
    logic        mem_clr = 1'b1;
    int          checks = 0;
    int          errors = 0;

    always #5 CLK_i = ~CLK_i;

    always @(posedge CLK_i) begin
        if (mem_clr) begin
            for (int i = 0; i < 2048; i++) mem[i] <= '0;
        end else if (WR_o) begin
            mem[ADDR_dm_o] <= IN_DATA_o;
        end
    end
    assign OUT_DATA_i = mem[ADDR_dm_o];

    dm_master #(.DATA_W(11), .ADDR_W(11)) dut (
        .CLK_i(CLK_i), .RST_n_i(RST_n_i),
        .CMD_VALID_i(CMD_VALID_i), .CMD_READY_o(CMD_READY_o),
        .CMD_OP_i(CMD_OP_i), .CMD_ADDR_i(CMD_ADDR_i), .CMD_SRC_i(CMD_SRC_i),
        .CMD_LEN_i(CMD_LEN_i), .CMD_DATA_i(CMD_DATA_i),
        .RSP_VALID_o(RSP_VALID_o), .RSP_DATA_o(RSP_DATA_o), .BUSY_o(BUSY_o),
        .WR_o(WR_o), .ADDR_dm_o(ADDR_dm_o), .IN_DATA_o(IN_DATA_o),
        .OUT_DATA_i(OUT_DATA_i)
    );

    // Issues one command from IDLE; rsp_cyc is the cycle of RSP_VALID counted
    // from the accept edge (-1 on timeout), wr_cnt the cycles with WR_o high.
    task automatic run_cmd(input logic [1:0] op, input logic [10:0] addr,
                           input logic [10:0] src, input logic [10:0] len,
                           input logic [10:0] data, output int rsp_cyc,
                           output int wr_cnt, output logic [10:0] rsp_data,
                           output logic pulse_after);
        int k;
        @(negedge CLK_i);
        CMD_OP_i = op; CMD_ADDR_i = addr; CMD_SRC_i = src;
        CMD_LEN_i = len; CMD_DATA_i = data; CMD_VALID_i = 1'b1;
        @(negedge CLK_i);
        CMD_VALID_i = 1'b0;
        k = 1;
        wr_cnt = 0;
        while (!RSP_VALID_o && k < 200) begin
            if (WR_o) wr_cnt++;
            @(negedge CLK_i);
            k++;
        end
        rsp_cyc  = RSP_VALID_o ? k : -1;
        rsp_data = RSP_DATA_o;
        if (WR_o) wr_cnt++;
        @(negedge CLK_i);
        pulse_after = RSP_VALID_o;
    endtask

    task automatic test_reset();
        int cyc, wrs; logic [10:0] d; logic p;
        repeat (2) @(negedge CLK_i);
        checks++; if ({CMD_READY_o, BUSY_o, RSP_VALID_o, WR_o} !== 4'b1000) begin errors++;
            $display("FAIL reset_ctrl: got %b expected 1000", {CMD_READY_o, BUSY_o, RSP_VALID_o, WR_o}); end
        checks++; if ({RSP_DATA_o, ADDR_dm_o, IN_DATA_o} !== 33'd0) begin errors++;
            $display("FAIL reset_data: got %h/%h/%h expected 0", RSP_DATA_o, ADDR_dm_o, IN_DATA_o); end
        mem_clr = 1'b0;
        RST_n_i = 1'b1;
        run_cmd(2'b01, 11'd1, 11'd0, 11'd0, 11'h002, cyc, wrs, d, p);
        checks++; if (cyc !== 2 || wrs !== 1 || p !== 1'b0) begin errors++;
            $display("FAIL write_timing: got cyc=%0d wr=%0d after=%b expected 2 1 0", cyc, wrs, p); end
        checks++; if (mem[1] !== 11'h002) begin errors++;
            $display("FAIL write_mem: got %h expected 002", mem[1]); end
        run_cmd(2'b00, 11'd1, 11'd0, 11'd0, 11'd0, cyc, wrs, d, p);
        checks++; if (cyc !== 2 || wrs !== 0 || d !== 11'h002) begin errors++;
            $display("FAIL read_back: got cyc=%0d wr=%0d data=%h expected 2 0 002", cyc, wrs, d); end
    endtask

    task automatic test_fill_wrap();
        int cyc, wrs; logic [10:0] d; logic p;
        logic [10:0] addrs [3];
        addrs[0] = 11'h7FE; addrs[1] = 11'h7FF; addrs[2] = 11'h000;
        run_cmd(2'b10, 11'h7FE, 11'd0, 11'd3, 11'h155, cyc, wrs, d, p);
        checks++; if (cyc !== 4 || wrs !== 3 || d !== 11'h155) begin errors++;
            $display("FAIL fill_rsp: got cyc=%0d wr=%0d data=%h expected 4 3 155", cyc, wrs, d); end
        for (int i = 0; i < 3; i++) begin
            run_cmd(2'b00, addrs[i], 11'd0, 11'd0, 11'd0, cyc, wrs, d, p);
            checks++; if (d !== 11'h155) begin errors++;
                $display("FAIL fill_read[%0d]: got %h expected 155", i, d); end
        end
        checks++; if (mem[11'h7FD] !== 11'h000 || mem[1] !== 11'h002) begin errors++;
            $display("FAIL fill_bounds: got %h/%h expected 000/002", mem[11'h7FD], mem[1]); end
    endtask

    task automatic test_copy();
        int cyc, wrs; logic [10:0] d; logic p;
        for (int i = 0; i < 4; i++)
            run_cmd(2'b01, 11'(10 + i), 11'd0, 11'd0, 11'(i + 1), cyc, wrs, d, p);
        run_cmd(2'b11, 11'd20, 11'd10, 11'd4, 11'd0, cyc, wrs, d, p);
        checks++; if (cyc !== 9 || wrs !== 4 || d !== 11'd4 || p !== 1'b0) begin errors++;
            $display("FAIL copy_rsp: got cyc=%0d wr=%0d data=%h after=%b expected 9 4 004 0", cyc, wrs, d, p); end
        for (int i = 0; i < 4; i++) begin
            run_cmd(2'b00, 11'(20 + i), 11'd0, 11'd0, 11'd0, cyc, wrs, d, p);
            checks++; if (d !== 11'(i + 1)) begin errors++;
                $display("FAIL copy_read[%0d]: got %h expected %h", i, d, 11'(i + 1)); end
        end
        checks++; if (mem[24] !== 11'd0 || mem[19] !== 11'd0) begin errors++;
            $display("FAIL copy_bounds: got %h/%h expected 0/0", mem[19], mem[24]); end
    endtask

    task automatic test_overlap_copy();
        int cyc, wrs; logic [10:0] d; logic p;
        run_cmd(2'b01, 11'd5, 11'd0, 11'd0, 11'd7, cyc, wrs, d, p);
        run_cmd(2'b01, 11'd6, 11'd0, 11'd0, 11'd9, cyc, wrs, d, p);
        run_cmd(2'b11, 11'd6, 11'd5, 11'd2, 11'd0, cyc, wrs, d, p);
        checks++; if (cyc !== 5 || d !== 11'd7) begin errors++;
            $display("FAIL overlap_rsp: got cyc=%0d data=%h expected 5 007", cyc, d); end
        run_cmd(2'b00, 11'd6, 11'd0, 11'd0, 11'd0, cyc, wrs, d, p);
        checks++; if (d !== 11'd7) begin errors++;
            $display("FAIL overlap_6: got %h expected 007", d); end
        run_cmd(2'b00, 11'd7, 11'd0, 11'd0, 11'd0, cyc, wrs, d, p);
        checks++; if (d !== 11'd7) begin errors++;
            $display("FAIL overlap_7: got %h expected 007", d); end
    endtask

    task automatic test_zero_len();
        int cyc, wrs; logic [10:0] d; logic p;
        run_cmd(2'b10, 11'd40, 11'd0, 11'd0, 11'h3FF, cyc, wrs, d, p);
        checks++; if (cyc !== 1 || wrs !== 0 || d !== 11'd7) begin errors++;
            $display("FAIL zero_fill: got cyc=%0d wr=%0d data=%h expected 1 0 007", cyc, wrs, d); end
        run_cmd(2'b11, 11'd41, 11'd10, 11'd0, 11'd0, cyc, wrs, d, p);
        checks++; if (cyc !== 1 || wrs !== 0 || d !== 11'd7) begin errors++;
            $display("FAIL zero_copy: got cyc=%0d wr=%0d data=%h expected 1 0 007", cyc, wrs, d); end
        checks++; if (mem[40] !== 11'd0 || mem[41] !== 11'd0) begin errors++;
            $display("FAIL zero_mem: got %h/%h expected 0/0", mem[40], mem[41]); end
    endtask

    task automatic test_reset_mid_fill();
        int seen = 0;
        logic rsp_seen = 1'b0;
        @(negedge CLK_i);
        CMD_OP_i = 2'b10; CMD_ADDR_i = 11'd100; CMD_LEN_i = 11'd8;
        CMD_DATA_i = 11'h0AA; CMD_VALID_i = 1'b1;
        @(negedge CLK_i);
        CMD_VALID_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (WR_o) seen++;
            @(negedge CLK_i);
        end
        RST_n_i = 1'b0;
        #1;
        checks++; if (WR_o !== 1'b0 || BUSY_o !== 1'b0 || seen !== 3) begin errors++;
            $display("FAIL mid_reset: got wr=%b busy=%b writes=%0d expected 0 0 3", WR_o, BUSY_o, seen); end
        repeat (2) @(negedge CLK_i);
        RST_n_i = 1'b1;
        repeat (12) begin
            @(negedge CLK_i);
            if (RSP_VALID_o) rsp_seen = 1'b1;
        end
        checks++; if (rsp_seen !== 1'b0 || CMD_READY_o !== 1'b1 || RSP_DATA_o !== 11'd0) begin errors++;
            $display("FAIL mid_reset_rsp: got rsp=%b ready=%b data=%h expected 0 1 000", rsp_seen, CMD_READY_o, RSP_DATA_o); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (mem[100 + i] !== ((i < 3) ? 11'h0AA : 11'h000)) begin errors++;
                $display("FAIL mid_reset_mem[%0d]: got %h expected %h", 100 + i, mem[100 + i], (i < 3) ? 11'h0AA : 11'h000); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rdy;
        logic [10:0] d;
        @(negedge CLK_i);
        CMD_OP_i = 2'b01; CMD_ADDR_i = 11'd30; CMD_DATA_i = 11'h011; CMD_VALID_i = 1'b1;
        @(negedge CLK_i);
        rdy[0] = CMD_READY_o;
        CMD_OP_i = 2'b00;
        @(negedge CLK_i);
        rdy[1] = CMD_READY_o;
        checks++; if (RSP_VALID_o !== 1'b1) begin errors++;
            $display("FAIL b2b_done: got rsp=%b expected 1", RSP_VALID_o); end
        @(negedge CLK_i);
        rdy[2] = CMD_READY_o;
        @(negedge CLK_i);
        rdy[3] = CMD_READY_o;
        CMD_VALID_i = 1'b0;
        checks++; if (rdy !== 4'b0100 || mem[30] !== 11'h011) begin errors++;
            $display("FAIL b2b_ready: got %b mem=%h expected 0100 011", rdy, mem[30]); end
        @(negedge CLK_i);
        d = RSP_DATA_o;
        checks++; if (RSP_VALID_o !== 1'b1 || d !== 11'h011) begin errors++;
            $display("FAIL b2b_read: got rsp=%b data=%h expected 1 011", RSP_VALID_o, d); end
        @(negedge CLK_i);
        checks++; if (RSP_VALID_o !== 1'b0 || CMD_READY_o !== 1'b1) begin errors++;
            $display("FAIL b2b_idle: got rsp=%b ready=%b expected 0 1", RSP_VALID_o, CMD_READY_o); end
    endtask

    initial begin
        test_reset();
        test_fill_wrap();
        test_copy();
        test_overlap_copy();
        test_zero_len();
        test_reset_mid_fill();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
